// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shifter.
// Bytes are queued from single-cycle stores and sent LSB first, with back-to-back frames when data waits.
module uart_transmitter #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       tx_busy
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W           = $clog2(SYMBOL_EDGE_TIME);
  localparam int unsigned PTR_W            = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W            = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic               serial_out_q, serial_out_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               push, pop, symbol_end;

  // Acceptance uses the pre-pop count, so a full FIFO refuses even while draining.
  assign push       = data_in_valid & (count_q != CNT_W'(FIFO_DEPTH));
  assign symbol_end = (baud_q == BAUD_W'(SYMBOL_EDGE_TIME - 1));

  // Frame sequencer; a pop always reloads the shifter and restarts the baud count.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    if (state_q != IDLE) begin
      baud_d = symbol_end ? '0 : baud_q + BAUD_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (symbol_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (symbol_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (symbol_end) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            baud_d  = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping and registered output values derived from next state.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    unique case (state_d)
      START:   serial_out_d = 1'b0;
      DATA:    serial_out_d = shift_d[0];
      default: serial_out_d = 1'b1;
    endcase
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    busy_d  = (state_d != IDLE) | (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      serial_out_q <= 1'b1;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      serial_out_q <= serial_out_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_in_ready = ready_q;
  assign serial_out    = serial_out_q;
  assign tx_busy       = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: accepted bytes are queued, a line monitor
// decodes each frame and checks symbol widths, stop bit, byte order and start timing.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]  exp_q[$];
  int          starts_q[$];
  logic [99:0] smp;
  int          mon_n = 0;
  bit          mon_active = 1'b0;
  int          mon_start = 0;

  uart_transmitter #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decode a captured 100-sample frame and score it against the oldest queued byte.
  task automatic finish_frame();
    logic       hold_ok;
    logic [7:0] got;
    logic [7:0] exp_b;
    hold_ok = 1'b1;
    for (int b = 0; b < 10; b++)
      for (int k = 1; k < 10; k++)
        if (smp[10*b+k] !== smp[10*b]) hold_ok = 1'b0;
    check_eq("bit_hold", 32'(hold_ok), 32'd1);
    check_eq("stop_bit", 32'(smp[90]), 32'd1);
    for (int b = 0; b < 8; b++) got[b] = smp[10*(b+1)];
    check_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      check_eq("frame_data", 32'(got), 32'(exp_b));
    end
    starts_q.push_back(mon_start);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (serial_out === 1'b0) begin
        mon_active = 1'b1;
        mon_start  = cyc;
        smp[0]     = 1'b0;
        mon_n      = 1;
      end
    end else begin
      smp[mon_n] = serial_out;
      mon_n++;
      if (mon_n == 100) begin
        mon_active = 1'b0;
        finish_frame();
      end
    end
  end

  // Called just after a rising edge; the byte is presented for one cycle.
  task automatic push_byte(input logic [7:0] b, input logic exp_rdy, input string tag);
    data_in       = b;
    data_in_valid = 1'b1;
    @(negedge clk);
    check_eq(tag, 32'(data_in_ready), 32'(exp_rdy));
    if (exp_rdy) exp_q.push_back(b);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in       = 8'hxx;
  endtask

  task automatic sample_at(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      ok = (exp_q.size() == 0) && !mon_active && (tx_busy === 1'b0);
    end
    check_eq(tag, 32'(ok), 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int first_start();
    return (starts_q.size() > 0) ? starts_q[0] : -1;
  endfunction

  function automatic int second_start();
    return (starts_q.size() > 1) ? starts_q[1] : -1;
  endfunction

  initial begin
    int t;
    rst           = 1'b1;
    data_in_valid = 1'b1;
    data_in       = 8'hAA;

    // Reset held with a pending write strobe.
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_serial", 32'(serial_out), 32'd1);
      check_eq("rst_ready", 32'(data_in_ready), 32'd1);
      check_eq("rst_busy", 32'(tx_busy), 32'd0);
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    data_in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("rst_no_frame", 32'(starts_q.size()), 32'd0);
    check_eq("rst_line_idle", 32'(mon_active), 32'd0);
    check_eq("rst_idle_busy", 32'(tx_busy), 32'd0);

    // Single byte: latency, bit pattern and busy drop.
    starts_q.delete();
    t = cyc;
    push_byte(8'hA5, 1'b1, "a5_ready");
    sample_at(t + 1);
    check_eq("a5_pre_start", 32'(serial_out), 32'd1);
    sample_at(t + 101);
    check_eq("a5_busy_last", 32'(tx_busy), 32'd1);
    sample_at(t + 102);
    check_eq("a5_busy_drop", 32'(tx_busy), 32'd0);
    wait_idle(300, "a5_timeout");
    check_eq("a5_start_cyc", 32'(first_start()), 32'(t + 2));

    // Back-to-back frames.
    starts_q.delete();
    t = cyc;
    push_byte(8'h00, 1'b1, "b2b_ready0");
    push_byte(8'hFF, 1'b1, "b2b_ready1");
    wait_idle(400, "b2b_timeout");
    check_eq("b2b_start0", 32'(first_start()), 32'(t + 2));
    check_eq("b2b_start1", 32'(second_start()), 32'(t + 102));

    // FIFO full: sixth byte refused, ready returns after the second pop.
    starts_q.delete();
    t = cyc;
    push_byte(8'h11, 1'b1, "full_rdy11");
    push_byte(8'h22, 1'b1, "full_rdy22");
    push_byte(8'h33, 1'b1, "full_rdy33");
    push_byte(8'h44, 1'b1, "full_rdy44");
    push_byte(8'h55, 1'b1, "full_rdy55");
    push_byte(8'h66, 1'b0, "full_rdy66");
    sample_at(t + 101);
    check_eq("full_rdy_still0", 32'(data_in_ready), 32'd0);
    sample_at(t + 102);
    check_eq("full_rdy_back", 32'(data_in_ready), 32'd1);
    wait_idle(800, "full_timeout");
    check_eq("full_frames", 32'(starts_q.size()), 32'd5);

    // Reset during data bit 3 of 0x0F with another byte queued.
    starts_q.delete();
    t = cyc;
    push_byte(8'h0F, 1'b1, "mid_rdy0f");
    push_byte(8'h81, 1'b1, "mid_rdy81");
    sample_at(t + 44);
    check_eq("mid_busy_pre", 32'(tx_busy), 32'd1);
    goto(t + 45);
    rst = 1'b1;
    exp_q.delete();
    sample_at(t + 46);
    check_eq("mid_serial", 32'(serial_out), 32'd1);
    check_eq("mid_busy", 32'(tx_busy), 32'd0);
    check_eq("mid_ready", 32'(data_in_ready), 32'd1);
    goto(t + 47);
    rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check_eq("mid_no_frame", 32'(starts_q.size()), 32'd0);
    check_eq("mid_line_idle", 32'(mon_active), 32'd0);

    // Push during STOP of the only queued byte: no idle gap.
    starts_q.delete();
    t = cyc;
    push_byte(8'h5A, 1'b1, "stop_rdy5a");
    goto(t + 95);
    push_byte(8'h3C, 1'b1, "stop_rdy3c");
    wait_idle(400, "stop_timeout");
    check_eq("stop_start0", 32'(first_start()), 32'(t + 2));
    check_eq("stop_start1", 32'(second_start()), 32'(t + 102));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required under 100000", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serializes bytes into standard 8N1 UART frames on `serial_out`.
- Sits on the TX side of the memory-mapped UART path. Consumes the `data_in_valid_tx` / `data_store_tx` strobe that the CPU-side UART control block issues on a store to 0x80000008.
- Returns `data_in_ready_tx`, which software reads as bit 0 of 0x80000000.
- A small FIFO decouples single-cycle CPU stores from the multi-thousand-cycle frame time.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s. SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, integer division, must be ≥ 2.
- FIFO_DEPTH, 4, byte buffer entries. Power of 2, ≥ 2.

Ports:
- clk, input, 1, core clock; all logic is rising-edge.
- reset, input, 1, synchronous, active-high reset.
- data_in, input, 8, byte to transmit; sampled when data_in_valid & data_in_ready.
- data_in_valid, input, 1, single-cycle (or held) write strobe from UART control.
- data_in_ready, output, 1, high when the FIFO is not full.
- serial_out, output, 1, UART TX line; idles high.
- tx_busy, output, 1, high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset (sync, active-high), effective on the clock edge where reset is sampled high:
  - serial_out=1, data_in_ready=1, tx_busy=0.
  - FIFO empty (rd_ptr=wr_ptr=0, count=0), FSM=IDLE, baud counter=0, bit index=0.
- Enqueue:
  - A push occurs on a cycle with data_in_valid=1 and data_in_ready=1.
  - The byte is written at wr_ptr, then wr_ptr and count are incremented.
  - data_in_valid while data_in_ready=0 is dropped. There is no overflow error; software must poll ready.
  - data_in_ready = (count != FIFO_DEPTH), combinational from the registered count.
- Pointers: log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH. count has log2(FIFO_DEPTH)+1 bits.
- FSM states:
  - IDLE: serial_out=1. If count != 0, pop the head byte into an internal shift register, then go to START. The pop decrements count and advances rd_ptr.
  - START: serial_out=0 for SYMBOL_EDGE_TIME cycles, then go to DATA.
  - DATA: serial_out = shift_reg[0], LSB first. Each bit is held SYMBOL_EDGE_TIME cycles, then the register shifts right. After bit 7 completes, go to STOP.
  - STOP: serial_out=1 for SYMBOL_EDGE_TIME cycles. When it ends, behaviour depends on the FIFO:
    - count != 0: pop and go directly to START, giving back-to-back frames with no extra idle cycle.
    - count == 0: go to IDLE.
- Latency: a push into an empty, IDLE transmitter drives serial_out low 2 cycles after the push edge (cycle 1: FIFO write; cycle 2: pop and START registered).
- serial_out is a registered output; there is no glitching.
- Frame length is exactly 10·SYMBOL_EDGE_TIME cycles from the first 0 to the end of the stop bit.
- Baud counter:
  - Counts 0 … SYMBOL_EDGE_TIME−1.
  - Wraps to 0 on every symbol boundary.
  - Is cleared on entering START.
- Simultaneous push and pop in the same cycle: count is unchanged, and both pointers advance.
  - When full, a push is refused even if a pop occurs that cycle, because ready is based on the pre-pop count.
  - The popped byte is always the oldest entry (FIFO order).
- tx_busy = (state != IDLE) | (count != 0).
- Reset mid-frame: the frame is abandoned and the FIFO contents are discarded. serial_out returns to 1 on the next edge, and no partial stop bit is emitted.
- data_in may change freely when it is not being sampled.

Test Plan:
- All scenarios use CLOCK_FREQ=1000, BAUD_RATE=100 (SYMBOL_EDGE_TIME=10).
- Reset:
  - Stimulus: hold reset 3 cycles with data_in_valid=1.
  - Required: serial_out=1, data_in_ready=1, tx_busy=0 throughout; no frame follows release.
- Single byte:
  - Stimulus: push 0xA5 at cycle t.
  - Required: serial_out falls at t+2 and carries 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level exactly 10 cycles.
  - Required: line stays 1 afterwards; tx_busy drops at t+102.
- Back-to-back:
  - Stimulus: push 0x00 then 0xFF on consecutive cycles.
  - Required: second start bit begins the cycle right after the first stop bit's 10th cycle; total low time 90 cycles, followed by the 0xFF frame.
- FIFO full:
  - Stimulus: push 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 on consecutive cycles.
  - Required: 0x66 is refused (ready=0 at that cycle); 0x11–0x55 are transmitted in order.
  - Required: ready returns to 1 on the cycle after a pop frees an entry.
- Reset mid-frame:
  - Stimulus: reset asserted during data bit 3 of 0x0F.
  - Required: serial_out=1 on the next edge, count=0, no further frames.
- Push during STOP of the last byte:
  - Stimulus: push 0x3C during STOP of the only queued byte.
  - Required: the next START follows the stop bit with no IDLE gap; 0x3C frames correctly.
